// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcode/state encodings and saturation limits for alu_seq   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int MAX_W = 64;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE     = ST_IDLE,
    MUL_BUSY = ST_MUL_BUSY
  } state_t;

  // OP_ADDC is only decoded when the carry build option is enabled.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_LHB  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_NOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_MUL  = 4'd8,
    OP_ADDC = 4'd9
  } alu_op_t;

  function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_if : issue/result handshake bundle for alu_seq               |
// | Optional C flag present when ALU_SEQ_CARRY_EN is defined. Rev 1.0    |
// +----------------------------------------------------------------------+
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  alu_pkg::alu_op_t      op;
  logic [WIDTH-1:0]      src0;
  logic [WIDTH-1:0]      src1;
  logic [SHW-1:0]        shamt;
  logic                  flag_we;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      dst;
  logic                  V;
  logic                  Z;
  logic                  N;
`ifdef ALU_SEQ_CARRY_EN
  logic                  C;
`endif

  modport master (
    output in_valid, op, src0, src1, shamt, flag_we, out_ready,
`ifdef ALU_SEQ_CARRY_EN
    input  C,
`endif
    input  in_ready, out_valid, dst, V, Z, N
  );

  modport slave (
    input  in_valid, op, src0, src1, shamt, flag_we, out_ready,
`ifdef ALU_SEQ_CARRY_EN
    output C,
`endif
    output in_ready, out_valid, dst, V, Z, N
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_mul : iterative radix-2 unsigned shift-add multiplier core   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mag_a,
  input  logic [WIDTH-1:0]     mag_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  step_sum;

  // prod carries the value the current step produces, so the final sum is
  // usable on the same edge that retires the last step.
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == C_LAST);
  assign prod     = step_sum;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == C_LAST) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq : handshaked saturating ALU with iterative signed multiply   |
// | Build option ALU_SEQ_CARRY_EN adds the C flag and ADDC. Rev 1.0      |
// +----------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  import alu_pkg::*;

  localparam logic [MAX_W-1:0] C_MAX_FULL = sat_max(WIDTH);
  localparam logic [MAX_W-1:0] C_MIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] C_MAX      = C_MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_MIN      = C_MIN_FULL[WIDTH-1:0];

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    dst_q, dst_d;
  logic                v_q, v_d, z_q, z_d, n_q, n_d;
  logic                mul_neg_q, mul_neg_d, mul_fwe_q, mul_fwe_d;

  logic                in_ready, accept;
  logic [WIDTH+1:0]    ext_a, ext_b, ext_res;
  logic [WIDTH-1:0]    alu_res, mul_res;
  logic                arith, legal, alu_ovf, mul_ovf;
  logic                mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [2*WIDTH-1:0]  mul_prod;

`ifdef ALU_SEQ_CARRY_EN
  logic                c_q, c_d, carry_new;
  logic [WIDTH:0]      carry_sum;
`endif

  assign in_ready = !rst && (state_q == IDLE) && !mul_busy && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign ext_a = {{2{bus.src0[WIDTH-1]}}, bus.src0};
  assign ext_b = {{2{bus.src1[WIDTH-1]}}, bus.src1};
  assign mag_a = bus.src0[WIDTH-1] ? -bus.src0 : bus.src0;
  assign mag_b = bus.src1[WIDTH-1] ? -bus.src1 : bus.src1;

  always_comb begin
    alu_res = '0;
    ext_res = '0;
    arith   = 1'b0;
    legal   = 1'b1;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD:  begin arith = 1'b1; ext_res = ext_a + ext_b; end
      OP_SUB:  begin arith = 1'b1; ext_res = ext_a - ext_b; end
`ifdef ALU_SEQ_CARRY_EN
      OP_ADDC: begin arith = 1'b1; ext_res = ext_a + ext_b + {{(WIDTH+1){1'b0}}, c_q}; end
`endif
      OP_LHB:  alu_res = {bus.src1[WIDTH-1:WIDTH/2], bus.src0[WIDTH/2-1:0]};
      OP_AND:  alu_res = bus.src0 & bus.src1;
      OP_NOR:  alu_res = ~(bus.src0 | bus.src1);
      OP_SLL:  alu_res = bus.src1 << bus.shamt;
      OP_SRL:  alu_res = bus.src1 >> bus.shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.src1) >>> bus.shamt);
      OP_MUL:  alu_res = '0;
      default: legal = 1'b0;
    endcase
    // The exact result fits in WIDTH bits only when the top three bits agree.
    if (arith) begin
      alu_ovf = (ext_res[WIDTH+1:WIDTH-1] != 3'b000) && (ext_res[WIDTH+1:WIDTH-1] != 3'b111);
      alu_res = alu_ovf ? (ext_res[WIDTH+1] ? C_MIN : C_MAX) : ext_res[WIDTH-1:0];
    end
  end

`ifdef ALU_SEQ_CARRY_EN
  always_comb begin
    carry_sum = {1'b0, bus.src0} + {1'b0, bus.src1}
              + {{WIDTH{1'b0}}, (bus.op == OP_ADDC) && c_q};
    carry_new = c_q;
    if (bus.op == OP_ADD || bus.op == OP_ADDC) begin
      carry_new = carry_sum[WIDTH];
    end else if (bus.op == OP_SUB) begin
      carry_new = bus.src0 < bus.src1;
    end
  end
`endif

  // A negative product may reach magnitude 2^(W-1); a positive one may not.
  always_comb begin
    if (mul_neg_q) begin
      mul_ovf = (|mul_prod[2*WIDTH-1:WIDTH]) || (mul_prod[WIDTH-1] && (|mul_prod[WIDTH-2:0]));
      mul_res = mul_ovf ? C_MIN : -mul_prod[WIDTH-1:0];
    end else begin
      mul_ovf = |mul_prod[2*WIDTH-1:WIDTH-1];
      mul_res = mul_ovf ? C_MAX : mul_prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    dst_d       = dst_q;
    v_d         = v_q;
    z_d         = z_q;
    n_d         = n_q;
    mul_neg_d   = mul_neg_q;
    mul_fwe_d   = mul_fwe_q;
    mul_start   = 1'b0;
`ifdef ALU_SEQ_CARRY_EN
    c_d         = c_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept && bus.op == OP_MUL) begin
          mul_start = 1'b1;
          mul_neg_d = bus.src0[WIDTH-1] ^ bus.src1[WIDTH-1];
          mul_fwe_d = bus.flag_we;
          state_d   = MUL_BUSY;
        end else if (accept) begin
          out_valid_d = 1'b1;
          dst_d       = alu_res;
          if (bus.flag_we && legal) begin
            z_d = (alu_res == '0);
            if (arith) begin
              v_d = alu_ovf;
              n_d = alu_res[WIDTH-1];
            end
`ifdef ALU_SEQ_CARRY_EN
            c_d = carry_new;
`endif
          end
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          dst_d       = mul_res;
          if (mul_fwe_q) begin
            z_d = (mul_res == '0);
            n_d = mul_res[WIDTH-1];
            v_d = mul_ovf;
`ifdef ALU_SEQ_CARRY_EN
            c_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      mul_neg_q   <= 1'b0;
      mul_fwe_q   <= 1'b0;
`ifdef ALU_SEQ_CARRY_EN
      c_q         <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      dst_q       <= dst_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      mul_neg_q   <= mul_neg_d;
      mul_fwe_q   <= mul_fwe_d;
`ifdef ALU_SEQ_CARRY_EN
      c_q         <= c_d;
`endif
    end
  end

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dst       = dst_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
`ifdef ALU_SEQ_CARRY_EN
  assign bus.C         = c_q;
`endif

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised-width, handshaked ALU; successor to the 16-bit single-cycle datapath ALU.
- Adds a valid/ready interface, a registered result stage and an iterative signed saturating multiply.
- Keeps V/Z/N internally with correct set/clear semantics. Sits between decode/register-read and writeback.

Parameters:
- WIDTH, 16, datapath width in bits (even, >= 8).
- SHW, $clog2(WIDTH), shift-amount width; localparam, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- op  in  4  opcode (alu_pkg::alu_op_t)
- src0  in  WIDTH  operand A
- src1  in  WIDTH  operand B / shift source
- shamt  in  SHW  shift amount
- flag_we  in  1  update flags when this op's result is registered
- out_valid  out  1  dst holds a result
- out_ready  in  1  consumer takes result
- dst  out  WIDTH  result register
- V, Z, N  out  1 each  registered overflow/zero/negative flags

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; out_valid=0; dst=0; V=Z=N=0; in_ready=0 during reset.
  - Mid-multiply reset aborts the operation with no result.
- Opcodes:
  - ADD=0, LHB=1, SUB=2, AND=3, NOR=4, SLL=5, SRL=6, SRA=7, MUL=8.
  - 9-15 illegal: treated as AND with result forced 0, flags untouched.
- Arithmetic:
  - ADD/SUB are two's-complement with signed saturation to 2^(W-1)-1 / -2^(W-1).
  - Overflow for ADD: operand signs equal and sum sign differs.
  - Overflow for SUB: operand signs differ and result sign differs from src0.
  - LHB = {src1[W-1:W/2], src0[W/2-1:0]}.
  - SLL/SRL/SRA shift src1 by shamt; SRA sign-fills.
  - MUL: signed src0*src1, 2W-bit product, saturated to W bits.
- Flags (when flag_we is captured with the op):
  - Z = (dst==0) for all ops.
  - N and V are written only for ADD/SUB/MUL: N=dst[W-1], V=saturation occurred.
  - Flags are written (set or cleared), never sticky. Logic/shift/LHB ops keep the prior N and V.
  - Flags update on the same edge that sets out_valid.
- FSM states IDLE, MUL_BUSY:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - IDLE, accept non-MUL: result registered next edge; out_valid=1; latency 1.
  - IDLE, accept MUL: latch operand magnitudes and sign; counter=0; go to MUL_BUSY.
  - MUL_BUSY: one radix-2 shift-add step per cycle for WIDTH cycles. On the last step, apply sign, saturate, register dst, out_valid=1, return to IDLE.
  - MUL latency is WIDTH+1 cycles from accept to out_valid.
- Output stage:
  - out_valid stays high and dst stays stable until out_valid && out_ready.
  - Drain and new accept in the same cycle are legal. out_valid stays 1 only if that accept is a non-MUL op.
  - out_ready has no effect while out_valid=0.
- Multiply edge cases:
  - -2^(W-1) * -1 saturates to 2^(W-1)-1 with V=1.
  - Any product of zero gives Z=1, N=0, V=0.

Optional Feature:
- Macro ALU_SEQ_CARRY_EN.
- Defined:
  - Adds output port C (1 bit) and opcode ADDC=9 (src0+src1+C, saturating as ADD).
  - C = unsaturated carry-out for ADD/ADDC and borrow-out for SUB; cleared by MUL; held by other ops.
  - C resets to 0.
- Undefined: no C port; opcode 9 is illegal.

Decomposition:
- alu_pkg:
  - alu_op_t enum (4-bit opcodes).
  - state_t enum (IDLE, MUL_BUSY).
  - sat_max/sat_min functions parametrised by width.
- Sub-module alu_seq_mul: iterative unsigned shift-add core.
  - Interface: start, mag_a, mag_b, busy, done, prod[2W-1:0].
  - alu_seq owns sign handling, saturation and flags.

Test Plan (WIDTH=16):
- ADD 0x7000+0x1000 with flag_we=1 -> dst=0x7FFF, V=1, N=0, Z=0; out_valid one cycle after accept.
- SUB 0x8000-0x0001 -> dst=0x8000, V=1, N=1. Then AND 0x00FF&0xFF00 -> dst=0x0000, Z=1, V=1 and N=1 retained. Then ADD 1+1 -> V=0, N=0, Z=0.
- MUL 0x0100*0x0100 -> 0x7FFF, V=1. MUL 0xFFFD*0x0005 -> 0xFFF1, N=1, V=0; out_valid exactly 17 cycles after accept; in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 3 cycles after a result -> dst stable, in_ready=0. Raise out_ready with a new ADD offered -> accepted on the drain cycle, next result the following cycle.
- Assert rst on cycle 5 of a MUL -> next cycle out_valid=0, V=Z=N=0, in_ready=1; no stale result appears.
- Shifts and LHB:
  - SRA 0x8888 by 8 -> 0xFF88.
  - SLL 0x0001 by 15 -> 0x8000, N unchanged.
  - LHB src0=0x1234, src1=0xAB00 -> 0xAB34.
  - flag_we=0 on any op -> flags unchanged.
